// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed 7-segment driver producing a rotating one-hot digit strobe and hgfedcba pattern
//   clk      in  1          system clock
//   rst_n    in  1          asynchronous reset, active low
//   en       in  1          scan enable; low blanks and holds the scanner in its reset state
//   number   in  4*w_digit  hex value, nibble i -> digit i
//   dots     in  w_digit    decimal point per digit
//   hgfedcba out 8          segment pattern, active high, bit7 = dot
//   digit    out w_digit    one-hot digit strobe, active high
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_segment_scanner #(
    parameter int w_digit   = 8,
    parameter int clk_mhz   = 50,
    parameter int update_hz = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [4*w_digit-1:0] number,
    input  logic [w_digit-1:0]   dots,
    output logic [7:0]           hgfedcba,
    output logic [w_digit-1:0]   digit
);
    localparam int period = clk_mhz * 1_000_000 / (update_hz * w_digit);
    localparam int cw     = $clog2(period + 1);
    localparam int iw     = $clog2(w_digit);

    if (period < 1) begin : g_bad_period
        $error("seven_segment_scanner: clk_mhz/update_hz/w_digit give a scan period below one clock");
    end

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    logic [cw-1:0]        cnt_q, cnt_d;
    logic [iw-1:0]        idx_q, idx_d;
    logic [4*w_digit-1:0] snap_num_q, snap_num_d;
    logic [w_digit-1:0]   snap_dots_q, snap_dots_d;
    logic [w_digit-1:0]   digit_q, digit_d;
    logic [7:0]           hgfedcba_q, hgfedcba_d;
    logic                 tick, frame, blank;
    logic [6:0]           seg;

    // The first digit of a frame is taken from the live inputs, which are
    // captured in the same edge so the rest of the frame cannot tear.
    always_comb begin
        tick        = cnt_q == cw'(period - 1);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = tick ? ((idx_q == iw'(w_digit - 1)) ? '0 : idx_q + 1'b1) : idx_q;
        frame       = tick && idx_d == '0;
        snap_num_d  = frame ? number : snap_num_q;
        snap_dots_d = frame ? dots : snap_dots_q;
        seg         = font(4'(snap_num_d >> {idx_d, 2'b00}));
`ifdef LEADING_ZERO_BLANK_EN
        blank       = idx_d != '0 && (snap_num_d >> {idx_d, 2'b00}) == '0;
`else
        blank       = 1'b0;
`endif
        hgfedcba_d  = tick ? {snap_dots_d[idx_d], blank ? 7'h00 : seg} : hgfedcba_q;
        digit_d     = tick ? (w_digit'(1) << idx_d) : digit_q;
        if (!en) begin
            cnt_d       = '0;
            idx_d       = iw'(w_digit - 1);
            snap_num_d  = '0;
            snap_dots_d = '0;
            hgfedcba_d  = '0;
            digit_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= iw'(w_digit - 1);
            snap_num_q  <= '0;
            snap_dots_q <= '0;
            hgfedcba_q  <= '0;
            digit_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_num_q  <= snap_num_d;
            snap_dots_q <= snap_dots_d;
            hgfedcba_q  <= hgfedcba_d;
            digit_q     <= digit_d;
        end
    end

    assign hgfedcba = hgfedcba_q;
    assign digit    = digit_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed bench with a frame-level reference model for seven_segment_scanner
module tb_seven_segment_scanner;
    localparam int W = 4;
    localparam int P = 2;
    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] number = '0;
    logic [3:0]  dots = '0;
    logic [7:0]  hgfedcba;
    logic [3:0]  digit;
    int          errs = 0;
    int          checks = 0;
    int          n = 0;
    logic [15:0] num_hist [0:4095];
    logic [3:0]  dots_hist [0:4095];

    seven_segment_scanner #(.w_digit(W), .clk_mhz(1), .update_hz(125000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .number(number), .dots(dots),
        .hgfedcba(hgfedcba), .digit(digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] ed, input logic [7:0] es);
        checks++;
        if (digit !== ed || hgfedcba !== es || !$onehot0(digit)) begin
            errs++;
            $display("FAIL %s at %0t: got digit=%b seg=%h, required digit=%b seg=%h", nm, $time, digit, hgfedcba, ed, es);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // n = clock edges seen while running; history of the inputs sampled at each edge.
    always @(posedge clk) begin
        if (!rst_n || !en) n <= 0;
        else begin
            n <= n + 1;
            num_hist[n + 1]  <= number;
            dots_hist[n + 1] <= dots;
        end
    end

    // Tick k happens at edge k*P and shows digit (k-1)%W; the frame it belongs to began at tick k-d.
    always @(negedge clk) begin
        logic [3:0] ed;
        logic [7:0] es;
        logic [15:0] fn;
        int k, d, e;
        ed = '0;
        es = '0;
        if (rst_n && n >= P) begin
            k  = n / P;
            d  = (k - 1) % W;
            e  = (k - d) * P;
            fn = num_hist[e];
            ed = 4'(1 << d);
            es = {dots_hist[e][d], (LZB && d > 0 && (fn >> (4 * d)) == 16'h0) ? 7'h00 : FONT[fn[4*d+:4]]};
        end
        chk("model", ed, es);
    end

    initial begin
        cyc(2);
        chk("reset", 4'b0000, 8'h00);
        en = 1'b1;
        number = 16'h1234;
        rst_n = 1'b1;
        cyc(1); chk("pre_first_strobe", 4'b0000, 8'h00);
        cyc(1); chk("t1_d0", 4'b0001, 8'h66);
        cyc(2); chk("t1_d1", 4'b0010, 8'h4F);
        cyc(2); chk("t1_d2", 4'b0100, 8'h5B);
        cyc(2); chk("t1_d3", 4'b1000, 8'h06);
        cyc(2); chk("t1_wrap", 4'b0001, 8'h66);
        cyc(4); chk("t2_d2_before", 4'b0100, 8'h5B);
        number = 16'hABCD;
        cyc(1); chk("t2_d2_hold", 4'b0100, 8'h5B);
        cyc(1); chk("t2_d3_old", 4'b1000, 8'h06);
        cyc(2); chk("t2_d0_new", 4'b0001, 8'h5E);
        cyc(2); chk("t2_d1_new", 4'b0010, 8'h39);
        cyc(2); chk("t2_d2_new", 4'b0100, 8'h7C);
        cyc(2); chk("t2_d3_new", 4'b1000, 8'h77);
        number = 16'h1234;
        dots = 4'b0010;
        cyc(2); chk("t3_d0", 4'b0001, 8'h66);
        cyc(2); chk("t3_d1_dot", 4'b0010, 8'hCF);
        cyc(2); chk("t3_d2", 4'b0100, 8'h5B);
        cyc(2); chk("t3_d3", 4'b1000, 8'h06);
        cyc(1);
        en = 1'b0;
        cyc(1); chk("t4_en_off", 4'b0000, 8'h00);
        cyc(2); chk("t4_en_off_hold", 4'b0000, 8'h00);
        en = 1'b1;
        cyc(1); chk("t4_restart_wait", 4'b0000, 8'h00);
        cyc(1); chk("t4_restart", 4'b0001, 8'h66);
        cyc(3);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_reset", 4'b0000, 8'h00);
        cyc(1);
        rst_n = 1'b1;
        number = 16'h0070;
        dots = 4'b0000;
        cyc(2); chk("t6_d0", 4'b0001, 8'h3F);
        cyc(2); chk("t6_d1", 4'b0010, 8'h07);
        cyc(2); chk("t6_d2", 4'b0100, LZB ? 8'h00 : 8'h3F);
        cyc(2); chk("t6_d3", 4'b1000, LZB ? 8'h00 : 8'h3F);
        number = 16'h0000;
        cyc(2); chk("t6_zero_d0", 4'b0001, 8'h3F);
        cyc(2); chk("t6_zero_d1", 4'b0010, LZB ? 8'h00 : 8'h3F);
        cyc(2); chk("t6_zero_d2", 4'b0100, LZB ? 8'h00 : 8'h3F);
        cyc(2); chk("t6_zero_d3", 4'b1000, LZB ? 8'h00 : 8'h3F);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
